// File: rtl/vga_sprite_capture_pkg.sv
// Shared definitions for the sprite-capture block and the 640x480 VGA timing logic.
// Holds the capture FSM encoding, standard timing constants and a saturating counter helper.
package vga_sprite_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    // 640x480 @ 60 Hz timing, in pixel clocks / lines
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int SPR_W_DEF = 82;
    localparam int SPR_H_DEF = 123;
    localparam int ADDR_W    = 14;
    localparam int POS_W     = 10;

    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (v == {POS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the incoming video, detects sync deassertion edges and tracks position.
// hpos/vline describe the pixel currently held in the first register stage.
module vga_sync_tracker
    import vga_sprite_capture_pkg::*;
(
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    output logic             hs_rise,
    output logic             vs_rise,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vline,
    output logic [2:0]       rgb_s1
);

    logic             hs_s1_reg;
    logic             hs_s2_reg;
    logic             vs_s1_reg;
    logic             vs_s2_reg;
    logic [2:0]       rgb_s1_reg;
    logic [POS_W-1:0] hpos_reg;
    logic [POS_W-1:0] vline_reg;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_s1_reg  <= 1'b1;
            hs_s2_reg  <= 1'b1;
            vs_s1_reg  <= 1'b1;
            vs_s2_reg  <= 1'b1;
            rgb_s1_reg <= 3'b000;
        end else begin
            hs_s1_reg  <= hsync;
            hs_s2_reg  <= hs_s1_reg;
            vs_s1_reg  <= vsync;
            vs_s2_reg  <= vs_s1_reg;
            rgb_s1_reg <= {red_in, green_in, blue_in};
        end
    end

    assign hs_rise = hs_s1_reg & ~hs_s2_reg;
    assign vs_rise = vs_s1_reg & ~vs_s2_reg;
    assign rgb_s1  = rgb_s1_reg;

    // Position is resolved combinationally so it reads 0 in the very edge cycle
    always_comb begin
        hpos = hs_rise ? '0 : sat_inc(hpos_reg);
    end

    always_comb begin
        vline = vline_reg;
        if (vs_rise) begin
            vline = '0;
        end else if (hs_rise) begin
            vline = sat_inc(vline_reg);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hpos_reg  <= '0;
            vline_reg <= '0;
        end else begin
            hpos_reg  <= hpos;
            vline_reg <= vline;
        end
    end

endmodule

// File: rtl/vga_sprite_capture.sv
// Captures a rectangular window of one full VGA frame into a sprite RAM, one write per pixel.
// Addresses come from a running counter since the window is scanned in raster order.
module vga_sprite_capture
    import vga_sprite_capture_pkg::*;
#(
    parameter int H_BP  = VGA_H_BP,
    parameter int V_BP  = VGA_V_BP,
    parameter int X0    = 0,
    parameter int Y0    = 0,
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              red_in,
    input  logic              green_in,
    input  logic              blue_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Window bounds expressed directly in hpos/vline units
    localparam logic [POS_W:0]    X_LO      = (POS_W + 1)'(H_BP + X0);
    localparam logic [POS_W:0]    X_HI      = (POS_W + 1)'(H_BP + X0 + SPR_W);
    localparam logic [POS_W:0]    Y_LO      = (POS_W + 1)'(V_BP + Y0);
    localparam logic [POS_W:0]    Y_HI      = (POS_W + 1)'(V_BP + Y0 + SPR_H);
    localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(SPR_W * SPR_H);

    logic             hs_rise;
    logic             vs_rise;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vline;
    logic [2:0]       rgb_s1;
    logic             in_window;

    cap_state_t        state_reg,    state_next;
    logic              wr_en_reg,    wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg,  wr_addr_next;
    logic [2:0]        wr_data_reg,  wr_data_next;
    logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
    logic              err_reg,      err_next;

    vga_sync_tracker u_tracker (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .hsync    (hsync),
        .vsync    (vsync),
        .red_in   (red_in),
        .green_in (green_in),
        .blue_in  (blue_in),
        .hs_rise  (hs_rise),
        .vs_rise  (vs_rise),
        .hpos     (hpos),
        .vline    (vline),
        .rgb_s1   (rgb_s1)
    );

    assign in_window = ({1'b0, hpos}  >= X_LO) && ({1'b0, hpos}  < X_HI) &&
                       ({1'b0, vline} >= Y_LO) && ({1'b0, vline} < Y_HI);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= 3'b000;
            addr_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            addr_cnt_reg <= addr_cnt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        addr_cnt_next = addr_cnt_reg;
        err_next      = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_WAIT_FRAME;
                    err_next   = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (vs_rise) begin
                    state_next    = ST_CAPTURE;
                    addr_cnt_next = '0;
                end
            end
            ST_CAPTURE: begin
                // Counter reaches PIX_TOTAL as the final write leaves the output register
                if (addr_cnt_reg == PIX_TOTAL) begin
                    state_next = ST_DONE;
                end else if (vs_rise) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else if (in_window) begin
                    wr_en_next    = 1'b1;
                    wr_addr_next  = addr_cnt_reg;
                    wr_data_next  = rgb_s1;
                    addr_cnt_next = addr_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign err     = err_reg;
    assign busy    = (state_reg == ST_WAIT_FRAME) || (state_reg == ST_CAPTURE);
    assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_vga_sprite_capture.sv
// Directed bench for vga_sprite_capture driven by a scaled-down VGA raster source.
// Expected writes are queued when a capture is requested and popped as wr_en appears.
module tb_vga_sprite_capture;

    localparam int HA = 20, HFP = 2, HS = 3, HB = 4;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VA = 12, VFP = 1, VS = 2, VB = 3;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int X0 = 6, Y0 = 2, SW = 8, SH = 5;
    localparam int NPIX = SW * SH;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;
    int h_cnt = 0, v_cnt = 0;
    int mode = 0;
    bit vs_force_low = 1'b0;
    int wr_seen = 0, done_seen = 0;
    int w0, d0, n;
    logic [16:0] exp_q[$];

    always #5 vga_clk = ~vga_clk;

    vga_sprite_capture #(
        .H_BP(HB), .V_BP(VB), .X0(X0), .Y0(Y0), .SPR_W(SW), .SPR_H(SH)
    ) dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .start    (start),
        .hsync    (hsync),
        .vsync    (vsync),
        .red_in   (red_in),
        .green_in (green_in),
        .blue_in  (blue_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    function automatic logic [2:0] pix(input int x, input int y);
        return (mode == 0) ? 3'b101 : 3'((x + y) % 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_pins();
        logic [2:0] c;
        c = (h_cnt < HA && v_cnt < VA) ? pix(h_cnt, v_cnt) : 3'b000;
        {red_in, green_in, blue_in} = c;
        hsync = !(h_cnt >= HA + HFP && h_cnt < HA + HFP + HS);
        vsync = !vs_force_low && !(v_cnt >= VA + VFP && v_cnt < VA + VFP + VS);
    endtask

    // One clock: sample outputs, score any write, then move the raster on
    task automatic tick();
        logic [16:0] e;
        @(posedge vga_clk);
        #1;
        if (wr_en === 1'b1) begin
            wr_seen++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[16:3]));
                chk("wr_data", 32'(wr_data), 32'(e[2:0]));
            end
        end
        if (done === 1'b1) done_seen++;
        if (h_cnt == HT - 1) begin
            h_cnt = 0;
            v_cnt = (v_cnt == VT - 1) ? 0 : v_cnt + 1;
        end else begin
            h_cnt++;
        end
        drive_pins();
    endtask

    task automatic push_rows(input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < SW; c++)
                exp_q.push_back({14'(r * SW + c), pix(X0 + c, Y0 + r)});
    endtask

    task automatic wait_pos(input int v, input int h);
        int k = 0;
        while (!(v_cnt == v && h_cnt == h) && k < 2 * FRAME) begin
            tick();
            k++;
        end
        chk("wait_pos", 32'(v_cnt == v && h_cnt == h), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_seen < target && k < 3 * FRAME) begin
            tick();
            k++;
        end
        chk("done_reached", 32'(done_seen), 32'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_capture(input int m);
        int ws, ds;
        mode = m;
        wait_pos(VA / 2, 0);
        pulse_start();
        chk("busy_armed", 32'(busy), 32'd1);
        push_rows(SH);
        ws = wr_seen;
        ds = done_seen;
        wait_pos(VA + VFP + VS, 0);
        chk("no_early_writes", 32'(wr_seen - ws), 32'd0);
        wait_done(ds + 1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(wr_seen - ws), 32'(NPIX));
        chk("err_clear", 32'(err), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        drive_pins();
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Constant colour, then diagonal pattern, both started mid-frame
        run_capture(0);
        run_capture(1);

        // Abort: vsync pulled low at the start of the second captured row
        mode = 1;
        wait_pos(VA / 2, 0);
        pulse_start();
        push_rows(1);
        w0 = wr_seen;
        d0 = done_seen;
        wait_pos(Y0 + 1, 0);
        vs_force_low = 1'b1;
        drive_pins();
        tick();
        vs_force_low = 1'b0;
        tick();
        repeat (FRAME) tick();
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        chk("abort_writes", 32'(wr_seen - w0), 32'(SW));
        chk("abort_queue", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a capture
        chk("err_sticky", 32'(err), 32'd1);
        wait_pos(VA / 2, 0);
        pulse_start();
        chk("err_cleared_by_start", 32'(err), 32'd0);
        push_rows(SH);
        w0 = wr_seen;
        d0 = done_seen;
        n = 0;
        while (wr_seen - w0 < 17 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("reached_write_17", 32'(wr_seen - w0), 32'd17);
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (FRAME) tick();
        chk("post_rst_writes", 32'(wr_seen - w0), 32'd17);
        chk("post_rst_no_done", 32'(done_seen - d0), 32'd0);

        // start held high: one capture per return to IDLE
        wait_pos(VA / 2, 0);
        start = 1'b1;
        push_rows(SH);
        push_rows(SH);
        w0 = wr_seen;
        d0 = done_seen;
        n = 0;
        while (done_seen < d0 + 2 && n < 4 * FRAME) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("held_two_done", 32'(done_seen - d0), 32'd2);
        repeat (2 * FRAME) tick();
        chk("held_done_total", 32'(done_seen - d0), 32'd2);
        chk("held_writes", 32'(wr_seen - w0), 32'(2 * NPIX));
        chk("held_queue", 32'(exp_q.size()), 32'd0);
        chk("held_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
